// File: rtl/axis_testpattern_checker.sv
// AXI-Stream receiver that checks an incrementing, wrapping test pattern and keeps error/beat stats.
// Define AXIS_TPC_RESYNC_EN to re-seed the expected value from received data after a mismatch.
module axis_testpattern_checker #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_START      = 0,
  parameter int COUNTER_END        = 255,
  parameter int COUNTER_INCR       = 1,
  parameter int READY_DIVIDER      = 1
) (
  input  logic                                 s_axis_aclk,
  input  logic                                 s_axis_aresetn,
  input  logic                                 enable,
  input  logic                                 clear,
  input  logic signed [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic                                 locked,
  output logic                                 error,
  output logic [31:0]                          error_count,
  output logic [31:0]                          beat_count
);

  localparam int W    = S_AXIS_TDATA_WIDTH;
  localparam int DivW = (READY_DIVIDER > 1) ? $clog2(READY_DIVIDER) : 1;

  localparam logic [DivW-1:0]      DivReload = DivW'(READY_DIVIDER - 1);
  localparam logic signed [W-1:0]  StartW    = W'(COUNTER_START);
  localparam logic signed [W-1:0]  EndW      = W'(COUNTER_END);
  localparam logic signed [W-1:0]  IncrW     = W'(COUNTER_INCR);
  // Values at or above WrapThr step past END and fold back toward START.
  localparam logic signed [W-1:0]  WrapThr   = W'(COUNTER_END - COUNTER_INCR + 1);
  localparam logic signed [W-1:0]  WrapAdj   = W'(COUNTER_INCR - (COUNTER_END - COUNTER_START) - 1);

  localparam logic [0:0] StHunt   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [DivW-1:0]     div_q;
  logic [0:0]          state_q, state_d;
  logic signed [W-1:0] exp_q, exp_d;
  logic                err_q, err_d;
  logic [31:0]         ecnt_q, ecnt_d;
  logic [31:0]         bcnt_q, bcnt_d;
  logic                beat;
  logic                in_range;

  function automatic logic signed [W-1:0] next_val(input logic signed [W-1:0] x);
    if (x >= WrapThr) return x + WrapAdj;
    else              return x + IncrW;
  endfunction

  assign s_axis_tready = enable & (div_q == '0) & s_axis_aresetn;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign in_range      = (s_axis_tdata >= StartW) && (s_axis_tdata <= EndW);

  assign locked      = (state_q == StLocked);
  assign error       = err_q;
  assign error_count = ecnt_q;
  assign beat_count  = bcnt_q;

  // Divider free-runs regardless of enable/clear so tready phase stays stable.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn)    div_q <= DivReload;
    else if (div_q == '0)   div_q <= DivReload;
    else                    div_q <= div_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    bcnt_d  = bcnt_q;
    if (clear) begin
      state_d = StHunt;
      exp_d   = StartW;
      err_d   = 1'b0;
      ecnt_d  = '0;
      bcnt_d  = '0;
    end else if (beat) begin
      bcnt_d = bcnt_q + 32'd1;
      if (state_q == StHunt) begin
        if (in_range) begin
          exp_d   = next_val(s_axis_tdata);
          state_d = StLocked;
        end
      end else if (s_axis_tdata == exp_q) begin
        exp_d = next_val(exp_q);
      end else begin
        err_d = 1'b1;
        if (ecnt_q != '1) ecnt_d = ecnt_q + 32'd1;
`ifdef AXIS_TPC_RESYNC_EN
        exp_d = next_val(s_axis_tdata);
`else
        exp_d = next_val(exp_q);
`endif
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state_q <= StHunt;
      exp_q   <= StartW;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Directed bench: default, wrapped-range (10..20 step 3) and divided-ready checker instances.
module tb_axis_testpattern_checker;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  // Instance A: defaults
  logic        en_a, clr_a, vld_a, rdy_a, lck_a, err_a;
  logic signed [31:0] dat_a;
  logic [31:0] ecnt_a, bcnt_a;
  // Instance B: START=10 END=20 INCR=3
  logic        en_b, clr_b, vld_b, rdy_b, lck_b, err_b;
  logic signed [31:0] dat_b;
  logic [31:0] ecnt_b, bcnt_b;
  // Instance C: READY_DIVIDER=4
  logic        en_c, clr_c, vld_c, rdy_c, lck_c, err_c;
  logic signed [31:0] dat_c;
  logic [31:0] ecnt_c, bcnt_c;

  axis_testpattern_checker dut_a (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn), .enable(en_a), .clear(clr_a),
    .s_axis_tdata(dat_a), .s_axis_tvalid(vld_a), .s_axis_tready(rdy_a),
    .locked(lck_a), .error(err_a), .error_count(ecnt_a), .beat_count(bcnt_a)
  );

  axis_testpattern_checker #(
    .COUNTER_START(10), .COUNTER_END(20), .COUNTER_INCR(3)
  ) dut_b (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn), .enable(en_b), .clear(clr_b),
    .s_axis_tdata(dat_b), .s_axis_tvalid(vld_b), .s_axis_tready(rdy_b),
    .locked(lck_b), .error(err_b), .error_count(ecnt_b), .beat_count(bcnt_b)
  );

  axis_testpattern_checker #(
    .READY_DIVIDER(4)
  ) dut_c (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn), .enable(en_c), .clear(clr_c),
    .s_axis_tdata(dat_c), .s_axis_tvalid(vld_c), .s_axis_tready(rdy_c),
    .locked(lck_c), .error(err_c), .error_count(ecnt_c), .beat_count(bcnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int d);
    dat_a = d;
    vld_a = 1'b1;
    tick();
  endtask

  task automatic send_b(input int d);
    dat_b = d;
    vld_b = 1'b1;
    tick();
  endtask

  int seq_b [9] = '{10, 13, 16, 19, 11, 14, 17, 20, 12};
  int highs;
  int last_hi;
  logic [31:0] b0;

  initial begin
    rstn = 1'b0;
    en_a = 1'b1; clr_a = 1'b0; vld_a = 1'b0; dat_a = '0;
    en_b = 1'b1; clr_b = 1'b0; vld_b = 1'b0; dat_b = '0;
    en_c = 1'b1; clr_c = 1'b0; vld_c = 1'b0; dat_c = '0;

    // Reset state
    tick();
    chk("rst_tready", {31'd0, rdy_a}, 32'd0);
    tick();
    chk("rst_locked", {31'd0, lck_a}, 32'd0);
    chk("rst_error",  {31'd0, err_a}, 32'd0);
    chk("rst_ecnt",   ecnt_a, 32'd0);
    chk("rst_bcnt",   bcnt_a, 32'd0);
    rstn = 1'b1;
    #1;
    chk("tready_en", {31'd0, rdy_a}, 32'd1);

    // 600 in-order beats with wrap at 255
    for (int i = 0; i < 600; i++) begin
      send_a(i % 256);
      if (i == 0) chk("lock_first", {31'd0, lck_a}, 32'd1);
    end
    vld_a = 1'b0;
    chk("inorder_bcnt", bcnt_a, 32'd600);
    chk("inorder_ecnt", ecnt_a, 32'd0);
    chk("inorder_err",  {31'd0, err_a}, 32'd0);
    chk("inorder_lck",  {31'd0, lck_a}, 32'd1);

    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr_bcnt", bcnt_a, 32'd0);
    chk("clr_lck",  {31'd0, lck_a}, 32'd0);

    // Slip: 0,1,2,4,5,6
    send_a(0); send_a(1); send_a(2); send_a(4); send_a(5); send_a(6);
    vld_a = 1'b0;
`ifdef AXIS_TPC_RESYNC_EN
    chk("slip_ecnt", ecnt_a, 32'd1);
`else
    chk("slip_ecnt", ecnt_a, 32'd3);
`endif
    chk("slip_err",  {31'd0, err_a}, 32'd1);
    chk("slip_lck",  {31'd0, lck_a}, 32'd1);
    chk("slip_bcnt", bcnt_a, 32'd6);

    // Clear with a same-cycle beat after 5 beats
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    send_a(0); send_a(1); send_a(2); send_a(7); send_a(8);
    chk("pre_clr_bcnt", bcnt_a, 32'd5);
`ifdef AXIS_TPC_RESYNC_EN
    chk("pre_clr_ecnt", ecnt_a, 32'd1);
`else
    chk("pre_clr_ecnt", ecnt_a, 32'd2);
`endif
    dat_a = 9; vld_a = 1'b1; clr_a = 1'b1;
    tick();
    clr_a = 1'b0; vld_a = 1'b0;
    chk("clrbeat_bcnt", bcnt_a, 32'd0);
    chk("clrbeat_ecnt", ecnt_a, 32'd0);
    chk("clrbeat_err",  {31'd0, err_a}, 32'd0);
    chk("clrbeat_lck",  {31'd0, lck_a}, 32'd0);
    send_a(50);
    chk("relock_lck",  {31'd0, lck_a}, 32'd1);
    chk("relock_bcnt", bcnt_a, 32'd1);
    send_a(51);
    chk("relock_ecnt", ecnt_a, 32'd0);

    // One-cycle reset mid-stream
    send_a(52);
    rstn = 1'b0; dat_a = 53; vld_a = 1'b1;
    #1;
    chk("midrst_tready", {31'd0, rdy_a}, 32'd0);
    tick();
    chk("midrst_lck",  {31'd0, lck_a}, 32'd0);
    chk("midrst_err",  {31'd0, err_a}, 32'd0);
    chk("midrst_ecnt", ecnt_a, 32'd0);
    chk("midrst_bcnt", bcnt_a, 32'd0);
    rstn = 1'b1;
    send_a(100);
    chk("postrst_lck",  {31'd0, lck_a}, 32'd1);
    chk("postrst_bcnt", bcnt_a, 32'd1);
    send_a(101);
    chk("postrst_ecnt", ecnt_a, 32'd0);
    vld_a = 1'b0;

    // Instance B: out-of-range in HUNT, then wrapped stream
    send_b(5);
    chk("b_hunt_lck",  {31'd0, lck_b}, 32'd0);
    chk("b_hunt_ecnt", ecnt_b, 32'd0);
    chk("b_hunt_bcnt", bcnt_b, 32'd1);
    for (int i = 0; i < 9; i++) send_b(seq_b[i]);
    vld_b = 1'b0;
    chk("b_wrap_ecnt", ecnt_b, 32'd0);
    chk("b_wrap_lck",  {31'd0, lck_b}, 32'd1);
    chk("b_wrap_bcnt", bcnt_b, 32'd10);

    // Instance C: tready one cycle in four
    vld_c = 1'b1;
    b0 = bcnt_c;
    highs = 0;
    last_hi = -1;
    for (int i = 0; i < 16; i++) begin
      if (rdy_c) begin
        if (last_hi >= 0) chk("c_gap", i - last_hi, 32'd4);
        last_hi = i;
        highs++;
      end
      tick();
    end
    chk("c_highs", highs, 32'd4);
    chk("c_beats", bcnt_c - b0, 32'd4);
    en_c = 1'b0;
    b0 = bcnt_c;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdy_c) highs++;
      tick();
    end
    chk("c_dis_highs", highs, 32'd0);
    chk("c_dis_beats", bcnt_c - b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/axis_testpattern_checker.md
AXIS_TESTPATTERN_CHECKER -- requirements
Module: axis_testpattern_checker

Interface
REQ-001 SHALL have parameter S_AXIS_TDATA_WIDTH, default 32: stream data width W.
REQ-002 SHALL have parameter COUNTER_START, default 0: lowest pattern value.
REQ-003 SHALL have parameter COUNTER_END, default 255: highest pattern value.
REQ-004 SHALL have parameter COUNTER_INCR, default 1: pattern step.
REQ-005 SHALL have parameter READY_DIVIDER, default 1: tready offered in one cycle out of N; 1 means always ready.
REQ-006 SHALL have port s_axis_aclk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port s_axis_aresetn  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port enable  in  1  1 = accept beats; 0 = hold s_axis_tready low.
REQ-009 SHALL have port clear  in  1  synchronous clear of state and statistics.
REQ-010 SHALL have port s_axis_tdata  in  W  received pattern word, signed.
REQ-011 SHALL have port s_axis_tvalid  in  1  upstream valid.
REQ-012 SHALL have port s_axis_tready  out  1  backpressure toward upstream.
REQ-013 SHALL have port locked  out  1  high while state is LOCKED.
REQ-014 SHALL have port error  out  1  sticky, set on first mismatch.
REQ-015 SHALL have port error_count  out  32  mismatch count, saturating at 2^32-1.
REQ-016 SHALL have port beat_count  out  32  accepted beats, wrapping modulo 2^32.

Function
REQ-017 A beat SHALL be accepted only on an edge where s_axis_tvalid and s_axis_tready are both 1.
REQ-018 Divider counter (width max(1, clog2(READY_DIVIDER))) SHALL free-run READY_DIVIDER-1 down to 0, then reload; it is unaffected by enable and clear.
REQ-019 s_axis_tready SHALL equal enable AND (divider counter == 0) AND s_axis_aresetn; READY_DIVIDER=1 gives tready = enable.
REQ-020 next(x) SHALL be x+COUNTER_INCR-(COUNTER_END-COUNTER_START)-1 if x >= COUNTER_END-COUNTER_INCR+1, else x+COUNTER_INCR; signed, W bits.
REQ-021 States SHALL be HUNT and LOCKED; reset and clear enter HUNT.
REQ-022 HUNT, accepted beat with COUNTER_START <= data <= COUNTER_END: expected <= next(data), go to LOCKED, no error.
REQ-023 HUNT, accepted beat out of range: remain in HUNT, no error counted.
REQ-024 LOCKED, data == expected: expected <= next(expected).
REQ-025 LOCKED, data != expected: error <= 1, error_count increments (held at 2^32-1 when saturated), expected updated per REQ-031/032, state stays LOCKED.
REQ-026 beat_count SHALL increment on every accepted beat in either state.
REQ-027 locked, error, error_count and beat_count SHALL be registered and SHALL reflect an accepted beat one cycle after its edge.
REQ-028 clear SHALL win over a same-cycle accepted beat: that beat is neither counted nor checked.

Reset
REQ-029 While s_axis_aresetn is low at an edge: state HUNT, expected = COUNTER_START, locked 0, error 0, error_count 0, beat_count 0, divider = READY_DIVIDER-1.
REQ-030 s_axis_tready SHALL be 0 in any cycle with s_axis_aresetn low; reset mid-stream discards the in-flight beat.

Configuration
REQ-031 With macro AXIS_TPC_RESYNC_EN defined: on mismatch, expected <= next(data), so one discontinuity yields exactly one error.
REQ-032 Without AXIS_TPC_RESYNC_EN: on mismatch, expected <= next(expected), so a slipped stream errors on every subsequent beat.

Verification
REQ-033 Defaults, in-order 0..255,0,1,... for 600 beats -> locked=1 after the first beat, error_count=0, beat_count=600, error=0.
REQ-034 Stream 0,1,2,4,5,6 -> without macro error_count=3; with AXIS_TPC_RESYNC_EN error_count=1; error=1 and locked=1 in both builds.
REQ-035 START=10, END=20, INCR=3, stream 10,13,16,19,11,14,17,20,12 -> error_count=0 across the wrap.
REQ-036 READY_DIVIDER=4, tvalid held high, enable=1 -> s_axis_tready high exactly 1 cycle in 4; beat_count +1 per 4 cycles; enable=0 -> tready=0.
REQ-037 clear with a same-cycle accepted beat after 5 beats and 2 errors -> next cycle beat_count=0, error_count=0, error=0, locked=0; relocks on the next in-range beat.
REQ-038 s_axis_aresetn low for 1 cycle mid-stream -> tready=0 that cycle, all outputs at reset values next cycle, relock on the first beat afterwards.
